// File: rtl/cla8bit_pkg.sv
// cla8bit_pkg -- shared types and constants for the 8-bit CLA response checker.
//   state_t   : checker FSM state (IDLE / RUN / DONE), also exported for debug
//   OP_W      : adder operand width
//   CNT_W     : vector counter / fail index width
//   ERR_W     : error counter width
//   ERR_SAT   : error counter saturation value
package cla8bit_pkg;

  localparam int OP_W  = 8;
  localparam int CNT_W = 16;
  localparam int ERR_W = 8;

  localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla8bit_checker_if.sv
// cla8bit_checker_if -- operand/result bus between the adder side and the checker.
//   start      : one-cycle pulse that begins or restarts a run
//   vld        : a/b/cin/s/cout/gg/pg form one vector this cycle
//   a, b, cin  : adder operands
//   s, cout    : adder sum and carry-out under test
//   gg, pg     : adder group generate / group propagate under test
// Handshake: valid-only. A vector is transferred on every rising clk edge where
// vld is high; there is no ready. The checker never stalls, it drops vectors it
// cannot use (outside a run, or once the run's vector quota has been accepted).
interface cla8bit_checker_if;
  import cla8bit_pkg::*;

  logic            start;
  logic            vld;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic            cin;
  logic [OP_W-1:0] s;
  logic            cout;
  logic            gg;
  logic            pg;

  modport master (output start, vld, a, b, cin, s, cout, gg, pg);
  modport slave  (input  start, vld, a, b, cin, s, cout, gg, pg);

endinterface

// File: rtl/cla8bit_ref.sv
// cla8bit_ref -- combinational golden model of the 8-bit carry look-ahead adder.
//   a, b, cin : operands
//   exp_s     : expected sum
//   exp_cout  : expected carry-out
//   exp_gg    : expected group generate (carry-out of a + b with cin = 0)
//   exp_pg    : expected group propagate (every bit position propagates)
module cla8bit_ref
  import cla8bit_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] exp_s,
  output logic            exp_cout,
  output logic            exp_gg,
  output logic            exp_pg
);

  logic [OP_W:0] sum_c;

  always_comb begin
    sum_c    = {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, cin};
    exp_s    = sum_c[OP_W-1:0];
    exp_cout = sum_c[OP_W];
    exp_pg   = &(a ^ b);
    // The carry-out with cin forced to 0 only differs from the real one when
    // a + b == 8'hFF (all positions propagate) and cin rippled through.
    exp_gg   = sum_c[OP_W] & ~(cin & exp_pg);
  end

endmodule

// File: rtl/cla8bit_checker.sv
// cla8bit_checker -- response checker for the 8-bit carry look-ahead adder.
// Consumes one adder vector per vld cycle through a 2-stage pipeline
// (stage 1: register + reference model, stage 2: counters / fail record) and
// reports pass/fail after NUM_VEC vectors.
// Build option: define CLA8BIT_CHECKER_GROUP_EN to also compare gg/pg.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : operand/result bus (start, vld, a, b, cin, s, cout, gg, pg)
//   busy       : run in progress
//   done       : run complete, held until next start or rst
//   pass       : valid with done, 1 = zero mismatches
//   vec_cnt    : vectors checked this run
//   err_cnt    : mismatching vectors, saturating at 255
//   fail_vld   : first-failure record captured
//   fail_a/b   : operands of first failing vector
//   fail_cin   : carry-in of first failing vector
//   fail_idx   : vec_cnt value of first failing vector (0-based)
//   state      : FSM state (debug)
module cla8bit_checker
  import cla8bit_pkg::*;
#(
  parameter int unsigned NUM_VEC = 16
) (
  input  logic             clk,
  input  logic             rst,
  cla8bit_checker_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_vld,
  output logic [OP_W-1:0]  fail_a,
  output logic [OP_W-1:0]  fail_b,
  output logic             fail_cin,
  output logic [CNT_W-1:0] fail_idx,
  output state_t           state
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VEC);

  state_t           state_q;
  logic             busy_q, done_q, pass_q;
  logic [CNT_W-1:0] acc_cnt_q, vec_cnt_q, fail_idx_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             fail_vld_q, fail_cin_q;
  logic [OP_W-1:0]  fail_a_q, fail_b_q;

  // Stage 1 vector register
  logic             s1_vld_q;
  logic [OP_W-1:0]  s1_a_q, s1_b_q, s1_s_q;
  logic             s1_cin_q, s1_cout_q, s1_gg_q, s1_pg_q;

  logic [OP_W-1:0]  exp_s;
  logic             exp_cout, exp_gg, exp_pg;
  logic             accept, mis;

  cla8bit_ref u_ref (
    .a        (s1_a_q),
    .b        (s1_b_q),
    .cin      (s1_cin_q),
    .exp_s    (exp_s),
    .exp_cout (exp_cout),
    .exp_gg   (exp_gg),
    .exp_pg   (exp_pg)
  );

  // acc_cnt counts vectors taken into stage 1, so the quota is enforced at the
  // input even while earlier vectors are still in flight.
  always_comb accept = (state_q == ST_RUN) && bus.vld && !bus.start && (acc_cnt_q != LAST);

`ifdef CLA8BIT_CHECKER_GROUP_EN
  always_comb mis = (s1_s_q != exp_s) || (s1_cout_q != exp_cout) ||
                    (s1_gg_q != exp_gg) || (s1_pg_q != exp_pg);
`else
  always_comb mis = (s1_s_q != exp_s) || (s1_cout_q != exp_cout);
  logic unused_grp;
  assign unused_grp = ^{exp_gg, exp_pg, s1_gg_q, s1_pg_q};
`endif

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      // rst returns to IDLE; start (any state) clears everything and runs.
      state_q    <= rst ? ST_IDLE : ST_RUN;
      busy_q     <= !rst;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      acc_cnt_q  <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      fail_vld_q <= 1'b0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_cin_q <= 1'b0;
      fail_idx_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_s_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_cout_q  <= 1'b0;
      s1_gg_q    <= 1'b0;
      s1_pg_q    <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        acc_cnt_q <= acc_cnt_q + 1'b1;
        s1_a_q    <= bus.a;
        s1_b_q    <= bus.b;
        s1_s_q    <= bus.s;
        s1_cin_q  <= bus.cin;
        s1_cout_q <= bus.cout;
        s1_gg_q   <= bus.gg;
        s1_pg_q   <= bus.pg;
      end
      unique case (state_q)
        ST_RUN: begin
          if (s1_vld_q) begin
            vec_cnt_q <= vec_cnt_q + 1'b1;
            if (mis) begin
              if (err_cnt_q != ERR_SAT) err_cnt_q <= err_cnt_q + 1'b1;
              if (!fail_vld_q) begin
                fail_vld_q <= 1'b1;
                fail_a_q   <= s1_a_q;
                fail_b_q   <= s1_b_q;
                fail_cin_q <= s1_cin_q;
                fail_idx_q <= vec_cnt_q;
              end
            end
          end else if (vec_cnt_q == LAST) begin
            // Pipeline is empty once the quota is accepted and s1 drained.
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_q == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign vec_cnt  = vec_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vld = fail_vld_q;
  assign fail_a   = fail_a_q;
  assign fail_b   = fail_b_q;
  assign fail_cin = fail_cin_q;
  assign fail_idx = fail_idx_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cla8bit_checker.sv
// tb_cla8bit_checker -- bench for cla8bit_checker with two instances
// (NUM_VEC = 4 and NUM_VEC = 300). Each completed run's expected result
// record is queued by the driver and compared when the DUT raises done.
module tb_cla8bit_checker;
  import cla8bit_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       gg;
    logic       pg;
  } vec_t;

  localparam int REC_W = 59;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla8bit_checker_if if4 ();
  cla8bit_checker_if if300 ();

  logic busy4, done4, pass4, fail_vld4, fail_cin4;
  logic [15:0] vec_cnt4, fail_idx4;
  logic [7:0] err_cnt4, fail_a4, fail_b4;
  state_t state4;

  logic busy3, done3, pass3, fail_vld3, fail_cin3;
  logic [15:0] vec_cnt3, fail_idx3;
  logic [7:0] err_cnt3, fail_a3, fail_b3;
  state_t state3;

  cla8bit_checker #(.NUM_VEC(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave),
    .busy(busy4), .done(done4), .pass(pass4), .vec_cnt(vec_cnt4), .err_cnt(err_cnt4),
    .fail_vld(fail_vld4), .fail_a(fail_a4), .fail_b(fail_b4), .fail_cin(fail_cin4),
    .fail_idx(fail_idx4), .state(state4)
  );

  cla8bit_checker #(.NUM_VEC(300)) dut300 (
    .clk(clk), .rst(rst), .bus(if300.slave),
    .busy(busy3), .done(done3), .pass(pass3), .vec_cnt(vec_cnt3), .err_cnt(err_cnt3),
    .fail_vld(fail_vld3), .fail_a(fail_a3), .fail_b(fail_b3), .fail_cin(fail_cin3),
    .fail_idx(fail_idx3), .state(state3)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [REC_W-1:0] exp_q[2][$];
  vec_t run_q[2][$];
  bit running[2];
  int num_vec[2] = '{4, 300};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic vec_t good(input logic [7:0] a, input logic [7:0] b, input logic cin);
    vec_t x;
    int total;
    total  = int'(a) + int'(b) + int'(cin);
    x.a    = a;
    x.b    = b;
    x.cin  = cin;
    x.s    = 8'(total % 256);
    x.cout = (total >= 256);
    x.gg   = (int'(a) + int'(b) >= 256);
    x.pg   = ((a ^ b) == 8'hFF);
    return x;
  endfunction

  function automatic logic [REC_W-1:0] model(input int sel);
    int errs = 0;
    bit fv = 0;
    logic [7:0] fa = '0, fb = '0;
    logic fc = 1'b0;
    logic [15:0] fi = '0;
    logic [7:0] err8;
    for (int i = 0; i < run_q[sel].size(); i++) begin
      vec_t x;
      vec_t r;
      bit bad;
      x = run_q[sel][i];
      r = good(x.a, x.b, x.cin);
      bad = (x.s != r.s) || (x.cout != r.cout);
`ifdef CLA8BIT_CHECKER_GROUP_EN
      bad = bad || (x.gg != r.gg) || (x.pg != r.pg);
`endif
      if (bad) begin
        errs++;
        if (!fv) begin
          fv = 1;
          fa = x.a;
          fb = x.b;
          fc = x.cin;
          fi = 16'(i);
        end
      end
    end
    err8 = (errs > 255) ? 8'd255 : 8'(errs);
    return {(errs == 0), err8, 16'(run_q[sel].size()), fv, fa, fb, fc, fi};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input int sel, input logic st, input logic v, input vec_t x);
    @(negedge clk);
    if (sel == 0) begin
      if4.start = st; if4.vld = v; if4.a = x.a; if4.b = x.b; if4.cin = x.cin;
      if4.s = x.s; if4.cout = x.cout; if4.gg = x.gg; if4.pg = x.pg;
      if300.start = 1'b0; if300.vld = 1'b0;
    end else begin
      if300.start = st; if300.vld = v; if300.a = x.a; if300.b = x.b; if300.cin = x.cin;
      if300.s = x.s; if300.cout = x.cout; if300.gg = x.gg; if300.pg = x.pg;
      if4.start = 1'b0; if4.vld = 1'b0;
    end
    if (st) begin
      running[sel] = 1;
      run_q[sel].delete();
    end else if (v && running[sel] && run_q[sel].size() < num_vec[sel]) begin
      run_q[sel].push_back(x);
      if (run_q[sel].size() == num_vec[sel]) begin
        exp_q[sel].push_back(model(sel));
        running[sel] = 0;
      end
    end
  endtask

  task automatic idle(input int sel, input int n);
    for (int i = 0; i < n; i++) drive_cycle(sel, 1'b0, 1'b0, '0);
  endtask

  function automatic vec_t corrupt(input vec_t x);
    vec_t y;
    y = x;
    case ($urandom_range(0, 3))
      0: y.s = x.s ^ 8'(1 << $urandom_range(0, 7));
      1: y.cout = ~x.cout;
      2: y.gg = ~x.gg;
      default: y.pg = ~x.pg;
    endcase
    return y;
  endfunction

  function automatic vec_t rand_vec();
    return good(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endfunction

  // ---------------- monitors ----------------
  logic prev4 = 1'b0, prev3 = 1'b0;

  always @(negedge clk) begin
    if (done4 && !prev4) begin
      if (exp_q[0].size() == 0) check("done4_unexpected", 64'd1, 64'd0);
      else check("run4_record", {pass4, err_cnt4, vec_cnt4, fail_vld4, fail_a4, fail_b4, fail_cin4, fail_idx4},
                 exp_q[0].pop_front());
    end
    prev4 = done4;
  end

  always @(negedge clk) begin
    if (done3 && !prev3) begin
      if (exp_q[1].size() == 0) check("done300_unexpected", 64'd1, 64'd0);
      else check("run300_record", {pass3, err_cnt3, vec_cnt3, fail_vld3, fail_a3, fail_b3, fail_cin3, fail_idx3},
                 exp_q[1].pop_front());
    end
    prev3 = done3;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  vec_t tbl[4];
  vec_t x;

  initial begin
    tbl[0] = '{a: 8'h01, b: 8'hFF, cin: 1'b0, s: 8'h00, cout: 1'b1, gg: 1'b1, pg: 1'b0};
    tbl[1] = '{a: 8'h00, b: 8'hF1, cin: 1'b1, s: 8'hF2, cout: 1'b0, gg: 1'b0, pg: 1'b0};
    tbl[2] = '{a: 8'h07, b: 8'h78, cin: 1'b1, s: 8'h80, cout: 1'b0, gg: 1'b0, pg: 1'b0};
    tbl[3] = '{a: 8'h0F, b: 8'hF0, cin: 1'b0, s: 8'hFF, cout: 1'b0, gg: 1'b0, pg: 1'b1};

    if4.start = 0; if4.vld = 0; if4.a = 0; if4.b = 0; if4.cin = 0;
    if4.s = 0; if4.cout = 0; if4.gg = 0; if4.pg = 0;
    if300.start = 0; if300.vld = 0; if300.a = 0; if300.b = 0; if300.cin = 0;
    if300.s = 0; if300.cout = 0; if300.gg = 0; if300.pg = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", 64'(state4), 64'(ST_IDLE));
    check("rst_flags", {busy4, done4, pass4, fail_vld4}, 4'b0000);
    check("rst_fields", {vec_cnt4, err_cnt4, fail_a4, fail_b4, fail_cin4, fail_idx4}, '0);
    rst = 1'b0;

    // vld in IDLE has no effect
    drive_cycle(0, 1'b0, 1'b1, tbl[0]);
    idle(0, 3);
    check("idle_vld_ignored", {64'(state4), vec_cnt4}, {64'(ST_IDLE), 16'd0});

    // Directed good run, with busy and done timing
    drive_cycle(0, 1'b1, 1'b0, '0);
    drive_cycle(0, 1'b0, 1'b0, '0);
    check("busy_after_start", busy4, 1'b1);
    for (int i = 0; i < 4; i++) drive_cycle(0, 1'b0, 1'b1, tbl[i]);
    idle(0, 2);
    check("done_not_yet", {done4, busy4}, 2'b01);
    idle(0, 1);
    check("done_at_3", {done4, busy4, pass4}, 3'b101);

    // vld in DONE is dropped
    drive_cycle(0, 1'b0, 1'b1, corrupt(tbl[1]));
    idle(0, 4);
    check("done_vld_ignored", {done4, vec_cnt4, err_cnt4}, {1'b1, 16'd4, 8'd0});

    // Vector 2 with wrong sum
    drive_cycle(0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      x = tbl[i];
      if (i == 2) x.s = 8'h81;
      drive_cycle(0, 1'b0, 1'b1, x);
    end
    idle(0, 4);

    // Correct s/cout but pg wrong: mismatch only with the group compare built in
    drive_cycle(0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      x = tbl[i];
      if (i == 3) x.pg = 1'b0;
      drive_cycle(0, 1'b0, 1'b1, x);
    end
    idle(0, 4);

    // Restart mid-run after 2 bad vectors, then 4 good ones
    drive_cycle(0, 1'b1, 1'b0, '0);
    drive_cycle(0, 1'b0, 1'b1, corrupt(tbl[0]));
    drive_cycle(0, 1'b0, 1'b1, corrupt(tbl[1]));
    drive_cycle(0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 1'b0, 1'b1, tbl[i]);
    idle(0, 4);

    // start with a same-cycle bad vld: start wins, the vector is dropped
    drive_cycle(0, 1'b1, 1'b1, corrupt(tbl[2]));
    for (int i = 0; i < 4; i++) drive_cycle(0, 1'b0, 1'b1, tbl[i]);
    idle(0, 4);

    // Randomized runs with gaps and occasional corruption
    for (int r = 0; r < 12; r++) begin
      drive_cycle(0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
        x = rand_vec();
        if ($urandom_range(0, 2) == 0) x = corrupt(x);
        drive_cycle(0, 1'b0, 1'b1, x);
        idle(0, $urandom_range(0, 2));
      end
      idle(0, 4);
    end

    // NUM_VEC = 300, every vector wrong in s, plus extra vectors that are dropped
    drive_cycle(1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 303; i++) begin
      x = rand_vec();
      x.s = x.s ^ 8'h01;
      drive_cycle(1, 1'b0, 1'b1, x);
      if ($urandom_range(0, 9) == 0) idle(1, 1);
    end
    idle(1, 5);
    check("sat_direct", {err_cnt3, vec_cnt3, fail_idx3}, {8'd255, 16'd300, 16'd0});

    // rst one cycle after a failing vld
    drive_cycle(0, 1'b1, 1'b0, '0);
    drive_cycle(0, 1'b0, 1'b1, corrupt(tbl[3]));
    @(negedge clk);
    if4.vld = 1'b0;
    rst = 1'b1;
    running[0] = 0;
    run_q[0].delete();
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_state", 64'(state4), 64'(ST_IDLE));
    check("rst_mid_flags", {busy4, done4, pass4, fail_vld4}, 4'b0000);
    idle(0, 2);
    check("rst_mid_fields", {fail_vld4, vec_cnt4, err_cnt4, fail_a4, fail_b4, fail_cin4, fail_idx4}, '0);

    idle(0, 3);
    check("queue4_drained", 64'(exp_q[0].size()), 64'd0);
    check("queue300_drained", 64'(exp_q[1].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
